// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e    : clear/ready state of the array
//   rf_addr_valid : 1 when an address names a writable/readable register
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

  // Out-of-range addresses and (optionally) x0 behave as "no register".
  function automatic logic rf_addr_valid(input int addr, input int nregs, input int zero_reg);
    return (addr < nregs) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_mp.
//   clk, rst  : clock, synchronous active-high reset (data -> 0)
//   clearing  : array is being cleared; enabled reads load 0
//   en        : load enable; 0 holds data
//   addr      : read address
//   w_en/w_addr/w_data : all write ports, for same-cycle forwarding
//   arr_data  : array contents at addr (0 when out of range)
//   data      : registered read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clearing,
  input  logic                    en,
  input  logic [AW-1:0]           addr,
  input  logic [NW-1:0]           w_en,
  input  logic [NW-1:0][AW-1:0]   w_addr,
  input  logic [NW-1:0][XLEN-1:0] w_data,
  input  logic [XLEN-1:0]         arr_data,
  output logic [XLEN-1:0]         data
);

  logic [XLEN-1:0] sel;

  // Later write ports override earlier ones, matching the array's write priority.
  always_comb begin
    sel = arr_data;
    for (int i = 0; i < NW; i++)
      if (w_en[i] && (w_addr[i] == addr)) sel = w_data[i];
    if (clearing || !rf_addr_valid(32'(addr), NREGS, ZERO_REG)) sel = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)     data <= '0;
    else if (en) data <= sel;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file.
//   clk, rst : clock, synchronous active-high reset
//   r_en     : per-read-port load enable (0 holds r_data)
//   r_addr   : read addresses
//   r_data   : registered read data, 1-cycle latency, write-forwarded
//   w_en     : per-write-port enable (ignored while clearing)
//   w_addr   : write addresses
//   w_data   : write data
//   ready    : array cleared, accesses accepted
// After reset the array is zeroed one entry per cycle rather than with a
// wide parallel reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR-1:0]           r_en,
  input  logic [NR-1:0][AW-1:0]   r_addr,
  output logic [NR-1:0][XLEN-1:0] r_data,
  input  logic [NW-1:0]           w_en,
  input  logic [NW-1:0][AW-1:0]   w_addr,
  input  logic [NW-1:0][XLEN-1:0] w_data,
  output logic                    ready
);

  logic [XLEN-1:0]         regs [NREGS];
  rf_state_e               state, state_n;
  logic [AW-1:0]           clr_idx;
  logic [NR-1:0][XLEN-1:0] arr_rd;

  // Clear FSM
  always_comb begin
    state_n = state;
    if (state == RF_CLEAR && clr_idx == AW'(NREGS - 1)) state_n = RF_READY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      if (state == RF_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  assign ready = (state == RF_READY);

  // Array: sequential clear, then writes. Loop order makes the highest
  // write port win on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int i = 0; i < NW; i++)
          if (w_en[i] && rf_addr_valid(32'(w_addr[i]), NREGS, ZERO_REG))
            regs[w_addr[i]] <= w_data[i];
      end
    end
  end

  // Read ports
  for (genvar j = 0; j < NR; j++) begin : g_rd
    // Guard the array index; the port itself zeroes invalid addresses.
    assign arr_rd[j] = (32'(r_addr[j]) < 32'(NREGS)) ? regs[r_addr[j]] : '0;

    regfile_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .NW(NW), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_rp (
      .clk     (clk),
      .rst     (rst),
      .clearing(state == RF_CLEAR),
      .en      (r_en[j]),
      .addr    (r_addr[j]),
      .w_en    (w_en),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .arr_data(arr_rd[j]),
      .data    (r_data[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (NREGS=32 and NREGS=24, NR=2, NW=2)
// share all stimulus; each is tracked by a behavioural model and checked
// every cycle, plus directed vectors and sequences.
module tb_regfile_mp;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            r_en;
  logic [1:0][4:0]       r_addr;
  logic [1:0]            w_en;
  logic [1:0][4:0]       w_addr;
  logic [1:0][31:0]      w_data;
  logic [1:0][31:0]      rd32, rd24;
  logic                  rdy32, rdy24;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NR(2), .NW(2), .ZERO_REG(1)) u32 (
    .clk(clk), .rst(rst), .r_en(r_en), .r_addr(r_addr), .r_data(rd32),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .ready(rdy32));

  regfile_mp #(.XLEN(32), .NREGS(24), .NR(2), .NW(2), .ZERO_REG(1)) u24 (
    .clk(clk), .rst(rst), .r_en(r_en), .r_addr(r_addr), .r_data(rd24),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .ready(rdy24));

  // ---------------- reference model ----------------
  int          nregs_m [2] = '{32, 24};
  logic [31:0] m_mem   [2][32];
  logic [31:0] m_rd    [2][2];
  logic        m_rdy   [2];
  int          m_cnt   [2];

  function automatic bit m_valid(int a, int n);
    return (a < n) && (a != 0);
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_cnt[d] = 0;
        m_rdy[d] = 1'b0;
        m_rd[d][0] = '0;
        m_rd[d][1] = '0;
      end else if (!m_rdy[d]) begin
        for (int j = 0; j < 2; j++) if (r_en[j]) m_rd[d][j] = '0;
        m_cnt[d]++;
        if (m_cnt[d] == nregs_m[d]) begin
          m_rdy[d] = 1'b1;
          for (int a = 0; a < 32; a++) m_mem[d][a] = '0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (r_en[j]) begin
            int a = int'(r_addr[j]);
            logic [31:0] v;
            v = '0;
            if (m_valid(a, nregs_m[d])) begin
              v = m_mem[d][a];
              if (w_en[0] && int'(w_addr[0]) == a) v = w_data[0];
              if (w_en[1] && int'(w_addr[1]) == a) v = w_data[1];
            end
            m_rd[d][j] = v;
          end
        end
        for (int i = 0; i < 2; i++)
          if (w_en[i] && m_valid(int'(w_addr[i]), nregs_m[d]))
            m_mem[d][int'(w_addr[i])] = w_data[i];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One clock: update model, take the edge, compare both instances.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ready32", 32'(rdy32), 32'(m_rdy[0]));
    chk("ready24", 32'(rdy24), 32'(m_rdy[1]));
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("model32_rd%0d", j), rd32[j], m_rd[0][j]);
      chk($sformatf("model24_rd%0d", j), rd24[j], m_rd[1][j]);
    end
  endtask

  task automatic idle_inputs();
    r_en = '0; r_addr = '0; w_en = '0; w_addr = '0; w_data = '0;
  endtask

  // Release reset and count cycles until each instance reports ready.
  task automatic wait_ready(output int c32, output int c24, input bit wr_junk);
    c32 = 0; c24 = 0;
    while (!rdy32 && c32 < 100) begin
      if (wr_junk && !rdy24) begin
        w_en = 2'b11; w_addr[0] = 5'd5; w_addr[1] = 5'd9;
        w_data[0] = 32'hDEADBEEF; w_data[1] = 32'hDEADBEEF;
      end else begin
        w_en = '0;
      end
      tick();
      c32++;
      if (rdy24 && c24 == 0) c24 = c32;
    end
    w_en = '0;
  endtask

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [31:0] e0, e1, e24_1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int c32, c24;

    tbl[0] = '{2'b11, 5'd0, 5'd5,  2'b01, 5'd5,  5'd0,  32'h12345678, 32'h0,
               32'h0,        32'h12345678, 32'h12345678};
    tbl[1] = '{2'b11, 5'd5, 5'd7,  2'b11, 5'd7,  5'd7,  32'h1,        32'h2,
               32'h12345678, 32'h2,        32'h2};
    tbl[2] = '{2'b11, 5'd7, 5'd0,  2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,
               32'h2,        32'h0,        32'h0};
    tbl[3] = '{2'b11, 5'd0, 5'd30, 2'b10, 5'd0,  5'd30, 32'h0,        32'hCAFEF00D,
               32'h0,        32'hCAFEF00D, 32'h0};
    tbl[4] = '{2'b11, 5'd3, 5'd30, 2'b01, 5'd3,  5'd0,  32'hA,        32'h0,
               32'hA,        32'hCAFEF00D, 32'h0};
    tbl[5] = '{2'b10, 5'd3, 5'd3,  2'b01, 5'd3,  5'd0,  32'hB,        32'h0,
               32'hA,        32'hB,        32'hB};
    tbl[6] = '{2'b11, 5'd3, 5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,
               32'hB,        32'hB,        32'hB};

    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = 1'b0; m_cnt[d] = 0; m_rd[d][0] = '0; m_rd[d][1] = '0;
      for (int a = 0; a < 32; a++) m_mem[d][a] = '0;
    end

    // Reset state and clear timing with a 3-cycle reset pulse and junk writes.
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_rdata0", rd32[0], 32'h0);
    chk("reset_ready", 32'(rdy32), 32'h0);
    rst = 1'b0;
    wait_ready(c32, c24, 1'b1);
    chk("clear_cycles32", 32'(c32), 32'd32);
    chk("clear_cycles24", 32'(c24), 32'd24);

    // Every register of the 32-entry file must read 0.
    r_en = 2'b11;
    for (int a = 0; a < 32; a++) begin
      r_addr[0] = 5'(a); r_addr[1] = 5'(31 - a);
      tick();
      chk("clear_zero_p0", rd32[0], 32'h0);
      chk("clear_zero_p1", rd32[1], 32'h0);
    end

    // Directed vectors: forwarding, collision, x0, out-of-range, stall hold.
    for (int k = 0; k < 7; k++) begin
      r_en = tbl[k].re; r_addr[0] = tbl[k].ra0; r_addr[1] = tbl[k].ra1;
      w_en = tbl[k].we; w_addr[0] = tbl[k].wa0; w_addr[1] = tbl[k].wa1;
      w_data[0] = tbl[k].wd0; w_data[1] = tbl[k].wd1;
      tick();
      chk($sformatf("vec%0d_p0", k), rd32[0], tbl[k].e0);
      chk($sformatf("vec%0d_p1", k), rd32[1], tbl[k].e1);
      chk($sformatf("vec%0d_n24_p1", k), rd24[1], tbl[k].e24_1);
    end
    idle_inputs();

    // Reset mid-clear restarts from index 0.
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midclear_not_ready", 32'(rdy32), 32'h0);
    rst = 1'b1; tick();
    rst = 1'b0;
    wait_ready(c32, c24, 1'b0);
    chk("midclear_cycles32", 32'(c32), 32'd32);
    chk("midclear_cycles24", 32'(c24), 32'd24);

    // Randomised traffic with addresses biased toward collisions.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      r_en = 2'($urandom);
      w_en = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        r_addr[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        w_addr[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        w_data[p] = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
